// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants, field widths, loader FSM state type and the
// opcode legality helper used by the instruction encoder/loader.
package mips_isa_pkg;

  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int WORD_W   = 32;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000110;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b000111;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } loaderState_t;

  // Exactly the opcode set the control unit decodes.
  function automatic logic isLegalOpcode(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational field-to-word packer for R/I-type MIPS instructions.
// With OPCODE_CHECK_EN defined, 'legal' flags opcodes the control unit decodes.
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMM_W-1:0]    imm,
  output logic [WORD_W-1:0]   word,
  output logic                legal
);

  assign word = (opcode == OP_RTYPE) ? {opcode, rs, rt, rd, shamt, funct}
                                     : {opcode, rs, rt, imm};

`ifdef OPCODE_CHECK_EN
  assign legal = isLegalOpcode(opcode);
`else
  assign legal = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction records and streams them into instruction memory from
// address 0. Optional opcode filtering and sticky err via OPCODE_CHECK_EN.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [SHAMT_W-1:0]  in_shamt,
  input  logic [FUNCT_W-1:0]  in_funct,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic                in_last,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     count,
  output logic                err
);

  localparam logic [ADDR_W-1:0] PTR_MAX   = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  loaderState_t      state, nextState;
  logic [ADDR_W-1:0] ptr;
  logic [WORD_W-1:0] packedWord;
  logic              opLegal;
  logic              accept;
  logic              writeEn;
  logic              sessionStart;

  instr_field_packer u_packer (
    .opcode (in_opcode),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .word   (packedWord),
    .legal  (opLegal)
  );

  assign in_ready     = (state == ST_LOAD);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign accept       = in_valid & in_ready;
  assign writeEn      = accept & opLegal;
  assign sessionStart = (state == ST_IDLE) & start;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nextState;
  end

  // NOTE: nextState gets its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (start) nextState = ST_LOAD;
      ST_LOAD: if (accept && (in_last || ptr == PTR_MAX)) nextState = ST_DONE;
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Write port is registered: the word appears the cycle after acceptance,
  // and a reset in that window simply drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
      count     <= '0;
    end else begin
      mem_we <= writeEn;
      if (sessionStart) begin
        ptr   <= '0;
        count <= '0;
      end else if (writeEn) begin
        mem_addr  <= ptr;
        mem_wdata <= packedWord;
        if (ptr != PTR_MAX)     ptr   <= ptr + 1'b1;
        if (count != COUNT_MAX) count <= count + 1'b1;
      end
    end
  end

`ifdef OPCODE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err <= 1'b0;
    else if (sessionStart)       err <= 1'b0;
    else if (accept && !opLegal) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: an ADDR_W=8 instance for the main
// scenarios and an ADDR_W=2 instance for the full-memory boundary.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        startSmall = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_opcode = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic        in_last = 1'b0;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;

  logic        readyS, weS, busyS, doneS, errS;
  logic [1:0]  addrS;
  logic [31:0] wdataS;
  logic [2:0]  countS;

  int evaluated = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .count(count), .err(err)
  );

  instr_encoder_loader #(.ADDR_W(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .start(startSmall), .in_valid(in_valid),
    .in_ready(readyS), .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_last(in_last), .mem_we(weS), .mem_addr(addrS),
    .mem_wdata(wdataS), .busy(busyS), .done(doneS), .count(countS), .err(errS)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    evaluated++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setRec(input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic last);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_funct  = fn;
    in_imm    = imm;
    in_last   = last;
  endtask

  task automatic idleIn();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_we",    mem_we,    0);
    check("rst_addr",  mem_addr,  0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_count", count,     0);
    check("rst_busy",  busy,      0);
    check("rst_ready", in_ready,  0);
    check("rst_done",  done,      0);
    check("rst_err",   err,       0);
    rst_n = 1'b1;
    tick();

    // Single R-type record with in_last
    pulseStart();
    check("t1_ready", in_ready, 1);
    check("t1_busy",  busy,     1);
    setRec(6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 1'b1);
    tick();
    idleIn();
    check("t1_we",    mem_we,    1);
    check("t1_addr",  mem_addr,  0);
    check("t1_wdata", mem_wdata, 32'h00221820);
    check("t1_done",  done,      1);
    check("t1_ready_done", in_ready, 0);
    check("t1_count", count,     1);
    tick();
    check("t1_we_off",   mem_we, 0);
    check("t1_done_off", done,   0);
    check("t1_idle",     busy,   0);
    check("t1_count_hold", count, 1);

    // lw then beq
    pulseStart();
    check("t2_count_clr", count, 0);
    setRec(6'b000100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 1'b0);
    tick();
    check("t2_we0",    mem_we,    1);
    check("t2_addr0",  mem_addr,  0);
    check("t2_wdata0", mem_wdata, 32'h10080004);
    check("t2_done0",  done,      0);
    setRec(6'b000110, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1);
    tick();
    idleIn();
    check("t2_we1",    mem_we,    1);
    check("t2_addr1",  mem_addr,  1);
    check("t2_wdata1", mem_wdata, 32'h1909FFFF);
    check("t2_done1",  done,      1);
    check("t2_count",  count,     2);
    tick();

    // in_valid pattern 1,0,1,1 (addi records, imm = 0x11/0x22/0x33)
    pulseStart();
    setRec(6'b000111, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0011, 1'b0);
    tick();
    check("t3_we_a",   mem_we,   1);
    check("t3_addr_a", mem_addr, 0);
    check("t3_data_a", mem_wdata, 32'h1C220011);
    idleIn();
    tick();
    check("t3_gap_we", mem_we, 0);
    setRec(6'b000111, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0022, 1'b0);
    tick();
    check("t3_we_b",   mem_we,   1);
    check("t3_addr_b", mem_addr, 1);
    setRec(6'b000111, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0033, 1'b1);
    tick();
    idleIn();
    check("t3_we_c",   mem_we,    1);
    check("t3_addr_c", mem_addr,  2);
    check("t3_data_c", mem_wdata, 32'h1C220033);
    check("t3_done",   done,      1);
    check("t3_count",  count,     3);
    tick();

    // ADDR_W=2: six records without in_last, memory fills after four
    startSmall = 1'b1;
    tick();
    startSmall = 1'b0;
    for (int j = 0; j < 6; j++) begin
      setRec(6'b000111, 5'd0, 5'(j), 5'd0, 5'd0, 6'd0, 16'(j), 1'b0);
      tick();
      if (j < 4) begin
        check($sformatf("t4_we%0d", j),   weS,    1);
        check($sformatf("t4_addr%0d", j), addrS,  j);
        check($sformatf("t4_data%0d", j), wdataS, {6'b000111, 5'd0, 5'(j), 16'(j)});
        check($sformatf("t4_done%0d", j), doneS,  (j == 3) ? 1 : 0);
      end else begin
        check($sformatf("t4_nowr%0d", j), weS,    0);
        check($sformatf("t4_nrdy%0d", j), readyS, 0);
      end
    end
    idleIn();
    check("t4_count", countS, 4);
    check("t4_big_untouched", mem_we, 0);
    tick();

    // Reset mid-session after the second accept
    pulseStart();
    setRec(6'b000111, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00AA, 1'b0);
    tick();
    setRec(6'b000111, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00BB, 1'b0);
    tick();
    check("t5_pre_count", count, 2);
    idleIn();
    rst_n = 1'b0;
    tick();
    check("t5_we",    mem_we,    0);
    check("t5_addr",  mem_addr,  0);
    check("t5_wdata", mem_wdata, 0);
    check("t5_count", count,     0);
    check("t5_busy",  busy,      0);
    check("t5_ready", in_ready,  0);
    rst_n = 1'b1;
    tick();
    pulseStart();
    setRec(6'b000101, 5'd2, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0010, 1'b1);
    tick();
    idleIn();
    check("t5_re_we",    mem_we,    1);
    check("t5_re_addr",  mem_addr,  0);
    check("t5_re_wdata", mem_wdata, 32'h14450010);
    tick();

    // Illegal opcode between two legal records
    pulseStart();
    setRec(6'b001010, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 1'b0);
    tick();
    check("t6_we0",   mem_we,   1);
    check("t6_addr0", mem_addr, 0);
    setRec(6'b111111, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0002, 1'b0);
    tick();
`ifdef OPCODE_CHECK_EN
    check("t6_we1_skip", mem_we, 0);
`else
    check("t6_we1",   mem_we,    1);
    check("t6_addr1", mem_addr,  1);
    check("t6_data1", mem_wdata, 32'hFC210002);
`endif
    setRec(6'b000000, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'h0000, 1'b1);
    tick();
    idleIn();
    check("t6_we2", mem_we, 1);
    check("t6_data2", mem_wdata, 32'h00853080);
    check("t6_done", done, 1);
`ifdef OPCODE_CHECK_EN
    check("t6_addr2", mem_addr, 1);
    check("t6_count", count,    2);
    check("t6_err",   err,      1);
`else
    check("t6_addr2", mem_addr, 2);
    check("t6_count", count,    3);
    check("t6_err",   err,      0);
`endif
    tick();
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
